// File: rtl/bitmask_scanner.sv
// ---------------------------------------------------------------------------
// bitmask_scanner
//
// Purpose:
//   Sparse-bit scanner feeding the bit-serial PE lanes. One 16-bit mask is
//   accepted per valid/ready transaction. The block then emits one beat per
//   set bit, MSB first, and clears each bit as its beat is consumed. Each beat
//   carries the bit index (15 minus bit position) and an ordinal within the
//   word. An all-zero mask produces a single filler beat flagged empty.
//
// Ports:
//   clk        - clock, all state updates on rising edge
//   reset      - synchronous, active-high reset
//   in_valid   - upstream mask available
//   in_ready   - block can accept a mask this cycle
//   in_mask    - 16-bit mask to scan, bit 15 highest priority
//   in_tag     - opaque sideband returned on every beat of that mask
//   out_valid  - beat available
//   out_ready  - downstream accepts beat
//   out_idx    - leading-one index, encoded 15 minus bit position
//   out_seq    - ordinal of this beat within the current mask
//   out_last   - final beat of the current mask
//   out_empty  - current mask was zero, beat carries no set bit
//   out_tag    - tag of the current mask
// ---------------------------------------------------------------------------

// 16-to-4 priority encoder: index of the highest set bit, encoded as
// 15 minus its position, so bit 15 maps to 0 and bit 0 maps to 15.
// An all-zero input encodes as 0.
module pencoder_16to4 (
   input  logic [15:0] data_i,
   output logic [3:0]  idx_o
);

   // Scan from the low end so the highest set bit is the last writer.
   always_comb begin
      idx_o = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (data_i[i]) begin
            idx_o = 4'(15 - i);
         end
      end
   end

endmodule

module bitmask_scanner #(
   parameter int TAG_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [15:0]          in_mask,
   input  logic [TAG_WIDTH-1:0] in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [3:0]           out_idx,
   output logic [3:0]           out_seq,
   output logic                 out_last,
   output logic                 out_empty,
   output logic [TAG_WIDTH-1:0] out_tag
);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [15:0]            mask_q, mask_d;
   logic [TAG_WIDTH-1:0]   tag_q, tag_d;
   logic [3:0]             seq_q, seq_d;
   logic                   empty_q, empty_d;

   logic [3:0]             leadIdx;
   logic                   singleBit;
   logic                   isLast;
   logic                   beatFire;
   logic                   acceptFire;

   pencoder_16to4 u_pencoder (
      .data_i (mask_q),
      .idx_o  (leadIdx)
   );

   // A mask with at most one bit set is on its final beat; clearing the
   // lowest set bit leaves zero exactly in that case. The empty flag covers
   // the zero-mask case explicitly.
   always_comb begin
      singleBit = ((mask_q & (mask_q - 16'd1)) == 16'd0);
      isLast    = empty_q || singleBit;
   end

   // Output decode: beat fields are only meaningful in SCAN and are forced
   // to zero in IDLE so downstream sees a clean bus between words.
   // in_ready opens on the last-beat handshake so back-to-back masks
   // stream without a bubble cycle.
   always_comb begin
      out_valid = 1'b0;
      out_idx   = 4'd0;
      out_seq   = 4'd0;
      out_last  = 1'b0;
      out_empty = 1'b0;
      out_tag   = '0;
      if (state_q == SCAN) begin
         out_valid = 1'b1;
         out_idx   = leadIdx;
         out_seq   = seq_q;
         out_last  = isLast;
         out_empty = empty_q;
         out_tag   = tag_q;
      end
      beatFire   = out_valid && out_ready;
      in_ready   = !reset && ((state_q == IDLE) || (beatFire && isLast));
      acceptFire = in_valid && in_ready;
   end

   // Next-state logic. A new mask can only arrive in IDLE or on the last
   // beat of the previous one, so loading takes priority over the beat
   // update. A non-last beat clears the bit it reported and bumps the
   // ordinal; a last beat without a following mask drops back to IDLE.
   // With no handshake on either side every register simply holds.
   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      tag_d   = tag_q;
      seq_d   = seq_q;
      empty_d = empty_q;
      if (acceptFire) begin
         state_d = SCAN;
         mask_d  = in_mask;
         tag_d   = in_tag;
         seq_d   = 4'd0;
         empty_d = (in_mask == 16'd0);
      end else if ((state_q == SCAN) && beatFire) begin
         if (isLast) begin
            state_d = IDLE;
         end else begin
            mask_d[4'd15 - leadIdx] = 1'b0;
            seq_d                   = seq_q + 4'd1;
         end
      end
   end

   // State register; reset discards any partially scanned mask.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         mask_q  <= 16'd0;
         tag_q   <= '0;
         seq_q   <= 4'd0;
         empty_q <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         tag_q   <= tag_d;
         seq_q   <= seq_d;
         empty_q <= empty_d;
      end
   end

endmodule

// File: tb/tb_bitmask_scanner.sv
// ---------------------------------------------------------------------------
// tb_bitmask_scanner
//
// Purpose:
//   Directed and randomised stimulus for bitmask_scanner. Inputs change 1 ns
//   after each rising edge and outputs are sampled 2 ns after it.
// ---------------------------------------------------------------------------
module tb_bitmask_scanner;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_mask;
   logic [7:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_idx;
   logic [3:0]  out_seq;
   logic        out_last;
   logic        out_empty;
   logic [7:0]  out_tag;

   int passCount;
   int totalCount;

   bitmask_scanner #(.TAG_WIDTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mask   (in_mask),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_seq   (out_seq),
      .out_last  (out_last),
      .out_empty (out_empty),
      .out_tag   (out_tag)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Drive all inputs, then let combinational outputs settle.
   task automatic applyStimulus(input logic v, input logic [15:0] m,
                                input logic [7:0] t, input logic r,
                                input logic rst);
      in_valid  = v;
      in_mask   = m;
      in_tag    = t;
      out_ready = r;
      reset     = rst;
      #1;
   endtask

   // One comparison point.
   task automatic checkOutput(input string name, input logic [31:0] observed,
                              input logic [31:0] expected);
      totalCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, observed, expected);
   endtask

   // Check every beat field at once.
   task automatic checkBeat(input string name, input logic v, input logic [3:0] idx,
                            input logic [3:0] seq, input logic last,
                            input logic empty, input logic [7:0] tag);
      checkOutput({name, "_valid"}, 32'(out_valid), 32'(v));
      checkOutput({name, "_idx"},   32'(out_idx),   32'(idx));
      checkOutput({name, "_seq"},   32'(out_seq),   32'(seq));
      checkOutput({name, "_last"},  32'(out_last),  32'(last));
      checkOutput({name, "_empty"}, 32'(out_empty), 32'(empty));
      checkOutput({name, "_tag"},   32'(out_tag),   32'(tag));
   endtask

   logic [15:0] rndMask;
   logic [15:0] remMask;
   logic [7:0]  rndTag;
   logic        rndReady;
   logic [3:0]  expIdx;
   int          beats;
   int          lastIdx;
   bit          done;

   initial begin
      passCount  = 0;
      totalCount = 0;

      // Reset
      applyStimulus(1'b0, 16'h0, 8'h0, 1'b0, 1'b1);
      nextCycle();
      nextCycle();
      checkOutput("rst_in_ready_held", 32'(in_ready), 32'd0);
      checkBeat("rst_held", 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 8'h00);
      applyStimulus(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
      checkOutput("rst_in_ready_released", 32'(in_ready), 32'd1);

      // Single mask 0x8001
      applyStimulus(1'b1, 16'h8001, 8'h5A, 1'b1, 1'b0);
      checkOutput("single_in_ready", 32'(in_ready), 32'd1);
      nextCycle();
      applyStimulus(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
      checkBeat("single_b0", 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 8'h5A);
      checkOutput("single_b0_in_ready", 32'(in_ready), 32'd0);
      nextCycle();
      applyStimulus(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
      checkBeat("single_b1", 1'b1, 4'd15, 4'd1, 1'b1, 1'b0, 8'h5A);
      nextCycle();
      applyStimulus(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
      checkBeat("single_idle", 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 8'h00);

      // Zero mask
      applyStimulus(1'b1, 16'h0000, 8'h33, 1'b1, 1'b0);
      nextCycle();
      applyStimulus(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
      checkBeat("zero_b0", 1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 8'h33);
      nextCycle();
      applyStimulus(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
      checkBeat("zero_idle", 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 8'h00);

      // Full mask followed back-to-back by 0x0010
      applyStimulus(1'b1, 16'hFFFF, 8'h01, 1'b1, 1'b0);
      nextCycle();
      for (int i = 0; i < 16; i++) begin
         if (i == 15) begin
            applyStimulus(1'b1, 16'h0010, 8'h02, 1'b1, 1'b0);
            checkOutput("full_last_in_ready", 32'(in_ready), 32'd1);
         end else begin
            applyStimulus(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
         end
         checkBeat("full_beat", 1'b1, 4'(i), 4'(i), (i == 15), 1'b0, 8'h01);
         nextCycle();
      end
      applyStimulus(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
      checkBeat("b2b_beat", 1'b1, 4'd11, 4'd0, 1'b1, 1'b0, 8'h02);
      nextCycle();
      applyStimulus(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
      checkOutput("b2b_idle_valid", 32'(out_valid), 32'd0);

      // Backpressure on 0x0300, out_ready pattern 0,0,1,0,1
      applyStimulus(1'b1, 16'h0300, 8'hC3, 1'b0, 1'b0);
      nextCycle();
      beats = 0;
      applyStimulus(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
      checkBeat("bp_stall0", 1'b1, 4'd6, 4'd0, 1'b0, 1'b0, 8'hC3);
      nextCycle();
      applyStimulus(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
      checkBeat("bp_stall1", 1'b1, 4'd6, 4'd0, 1'b0, 1'b0, 8'hC3);
      nextCycle();
      applyStimulus(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
      checkBeat("bp_fire0", 1'b1, 4'd6, 4'd0, 1'b0, 1'b0, 8'hC3);
      if (out_valid && out_ready) beats++;
      nextCycle();
      applyStimulus(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
      checkBeat("bp_stall2", 1'b1, 4'd7, 4'd1, 1'b1, 1'b0, 8'hC3);
      checkOutput("bp_stall2_in_ready", 32'(in_ready), 32'd0);
      nextCycle();
      applyStimulus(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
      checkBeat("bp_fire1", 1'b1, 4'd7, 4'd1, 1'b1, 1'b0, 8'hC3);
      if (out_valid && out_ready) beats++;
      nextCycle();
      applyStimulus(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
      if (out_valid && out_ready) beats++;
      checkOutput("bp_beat_count", 32'(beats), 32'd2);
      checkOutput("bp_idle_valid", 32'(out_valid), 32'd0);

      // Reset mid-scan on 0xF000
      applyStimulus(1'b1, 16'hF000, 8'h77, 1'b1, 1'b0);
      nextCycle();
      applyStimulus(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
      checkBeat("mid_b0", 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 8'h77);
      nextCycle();
      applyStimulus(1'b0, 16'h0, 8'h0, 1'b1, 1'b1);
      checkOutput("mid_in_ready_in_reset", 32'(in_ready), 32'd0);
      nextCycle();
      applyStimulus(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
      checkBeat("mid_after_reset", 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 8'h00);
      checkOutput("mid_in_ready_after", 32'(in_ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         nextCycle();
         applyStimulus(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
         checkOutput("mid_no_residual", 32'(out_valid), 32'd0);
      end

      // Random masks with random out_ready against a scoreboard
      for (int n = 0; n < 1000; n++) begin
         rndMask = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
         rndTag  = 8'($urandom);
         applyStimulus(1'b1, rndMask, rndTag, 1'b0, 1'b0);
         checkOutput("rnd_in_ready", 32'(in_ready), 32'd1);
         nextCycle();
         remMask = rndMask;
         beats   = 0;
         lastIdx = -1;
         done    = 1'b0;
         for (int c = 0; c < 200 && !done; c++) begin
            rndReady = 1'($urandom_range(0, 1));
            applyStimulus(1'b0, 16'h0, 8'h0, rndReady, 1'b0);
            if (out_valid && rndReady) begin
               expIdx = 4'd0;
               for (int b = 0; b < 16; b++) begin
                  if (remMask[b]) expIdx = 4'(15 - b);
               end
               checkOutput("rnd_idx", 32'(out_idx), 32'(expIdx));
               checkOutput("rnd_seq", 32'(out_seq), 32'(beats));
               checkOutput("rnd_tag", 32'(out_tag), 32'(rndTag));
               checkOutput("rnd_empty", 32'(out_empty), 32'(rndMask == 16'h0));
               checkOutput("rnd_last", 32'(out_last), 32'($countones(remMask) <= 1));
               checkOutput("rnd_order", 32'(int'(out_idx) > lastIdx), 32'd1);
               lastIdx = int'(out_idx);
               if (rndMask != 16'h0) remMask[4'd15 - expIdx] = 1'b0;
               beats++;
               if (out_last) done = 1'b1;
            end
            nextCycle();
         end
         applyStimulus(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
         checkOutput("rnd_done", 32'(done), 32'd1);
         checkOutput("rnd_beat_count", 32'(beats),
                     (rndMask == 16'h0) ? 32'd1 : 32'($countones(rndMask)));
         checkOutput("rnd_idle", 32'(out_valid), 32'd0);
      end

      $display("[TB] %0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
